// File: rtl/seven_seg_pkg.sv
// Shared glyph table and sizing helper for the seven-segment controller.
// Glyphs are active-high, bit 0 = segment a .. bit 6 = segment g.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational nibble to active-high segment decoder.
// b and d use lowercase glyphs so they stay distinct from 8 and 0.
module seven_seg_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// Multiplexed seven-segment controller with frame-synchronous load.
// Optional BRIGHTNESS_EN adds a 4-bit per-slot anode duty control.
module seven_seg_display_ctrl
    import seven_seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int DIV_BITS   = 17,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  load,
`ifdef BRIGHTNESS_EN
    input  logic [3:0]            brightness,
`endif
    output logic                  load_ack,
    output logic                  frame_done,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int IW = idx_width(DIGITS);
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [DIV_BITS-1:0] cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                pend_q, pend_d;
    logic [4*DIGITS-1:0] sh_val_q, sh_val_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]   sh_en_q, sh_en_d;
    logic [4*DIGITS-1:0] act_val_q, act_val_d;
    logic [DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [DIGITS-1:0]   act_en_q, act_en_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                ack_q, ack_d;
    logic                fd_q, fd_d;

    logic                tick;
    logic                wrap;
    logic                gate;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_en;
    logic [6:0]          glyph;

    assign tick = &cnt_q;
    assign wrap = tick && (idx_q == LAST);

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib = act_val_q[4*i +: 4];
                cur_dp  = act_dp_q[i];
                cur_en  = act_en_q[i];
            end
        end
    end

    seven_seg_hex_decode u_dec (
        .nibble (cur_nib),
        .seg    (glyph)
    );

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Shadow swaps into active only at frame wrap, so a frame never mixes data.
    always_comb begin
        sh_val_d  = sh_val_q;
        sh_dp_d   = sh_dp_q;
        sh_en_d   = sh_en_q;
        pend_d    = pend_q;
        act_val_d = act_val_q;
        act_dp_d  = act_dp_q;
        act_en_d  = act_en_q;
        if (wrap) begin
            pend_d = 1'b0;
            if (pend_q) begin
                act_val_d = sh_val_q;
                act_dp_d  = sh_dp_q;
                act_en_d  = sh_en_q;
            end
        end
        if (load) begin
            sh_val_d = value;
            sh_dp_d  = dp_in;
            sh_en_d  = digit_en;
            pend_d   = 1'b1;
        end
        ack_d = wrap && pend_q;
        fd_d  = wrap;
    end

`ifdef BRIGHTNESS_EN
    assign gate = (cnt_d[DIV_BITS-1 -: 4] < brightness);
`else
    assign gate = 1'b1;
`endif

    always_comb begin
        sel_d = sel_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        if (tick) begin
            sel_d = DIGITS'(1) << idx_q;
            seg_d = (cur_en ? glyph : SEG_BLANK) ^ {7{POL}};
            dp_d  = (cur_en && cur_dp) ^ POL;
        end
        an_d = (sel_d & {DIGITS{gate}}) ^ {DIGITS{POL}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            pend_q    <= 1'b0;
            sh_val_q  <= '0;
            sh_dp_q   <= '0;
            sh_en_q   <= '0;
            act_val_q <= '0;
            act_dp_q  <= '0;
            act_en_q  <= '0;
            sel_q     <= '0;
            an_q      <= {DIGITS{POL}};
            seg_q     <= {7{POL}};
            dp_q      <= POL;
            ack_q     <= 1'b0;
            fd_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            sh_val_q  <= sh_val_d;
            sh_dp_q   <= sh_dp_d;
            sh_en_q   <= sh_en_d;
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
            act_en_q  <= act_en_d;
            sel_q     <= sel_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            ack_q     <= ack_d;
            fd_q      <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign load_ack   = ack_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Scoreboard bench for seven_seg_display_ctrl, DIGITS=4, DIV_BITS=2, active-low.
// Expected slots and load_ack values are queued by stimulus, popped by a monitor.
module tb_seven_seg_display_ctrl;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic        load = 1'b0;
    logic        load_ack;
    logic        frame_done;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    slot_t sb[$];
    bit    ack_exp[$];

    always #5 clk = ~clk;

    seven_seg_display_ctrl #(
        .DIGITS     (4),
        .DIV_BITS   (2),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .value      (value),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
`ifdef BRIGHTNESS_EN
        .brightness (4'd15),
`endif
        .load_ack   (load_ack),
        .frame_done (frame_done),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] dps);
        logic [6:0] s [4];
        slot_t e;
        s[0] = s0;
        s[1] = s1;
        s[2] = s2;
        s[3] = s3;
        for (int i = 0; i < 4; i++) begin
            e.an  = ~(4'b0001 << i);
            e.seg = s[i];
            e.dp  = dps[i];
            sb.push_back(e);
        end
    endtask

    task automatic push_blank();
        push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                           input logic [3:0] en);
        value    = v;
        dp_in    = d;
        digit_en = en;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_fd();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout: got none expected pulse");
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_seg", 16'(seg), 16'h7F);
        chk("rst_dp", 16'(dp), 16'h1);
        chk("rst_ack", 16'(load_ack), 16'h0);
        chk("rst_fd", 16'(frame_done), 16'h0);
    endtask

    logic [3:0] prev_an = 4'hF;
    int         cyc = 0;
    bit         fd_seen = 1'b0;

    always @(negedge clk) begin
        slot_t e;
        bit    a;
        if (!reset_n) begin
            prev_an = 4'hF;
            cyc     = 0;
            fd_seen = 1'b0;
        end else begin
            cyc++;
            if (an !== prev_an && an !== 4'hF) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL slot_unexpected: got an=%b expected none", an);
                end else begin
                    e = sb.pop_front();
                    chk("slot_an", 16'(an), 16'(e.an));
                    chk("slot_seg", 16'(seg), 16'(e.seg));
                    chk("slot_dp", 16'(dp), 16'(e.dp));
                end
            end
            prev_an = an;
            if (frame_done === 1'b1) begin
                if (fd_seen) chk("frame_period", 16'(cyc), 16'd16);
                fd_seen = 1'b1;
                cyc     = 0;
                if (ack_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected_frame: got fd expected none");
                end else begin
                    a = ack_exp.pop_front();
                    chk("load_ack", 16'(load_ack), 16'(a));
                end
            end else if (load_ack !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL ack_without_fd: got %b expected 0", load_ack);
            end
        end
    end

    initial begin
        push_blank();
        ack_exp.push_back(1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_reset_state();

        wait_fd();
        push_blank();
        ack_exp.push_back(1'b1);
        repeat (3) @(negedge clk);
        do_load(16'h12AF, 4'b0100, 4'hF);

        wait_fd();
        push_frame(7'h0E, 7'h08, 7'h24, 7'h79, 4'b1011);
        ack_exp.push_back(1'b1);
        @(negedge clk);
        do_load(16'h1111, 4'h0, 4'hF);
        @(negedge clk);
        do_load(16'h2222, 4'h0, 4'hF);

        wait_fd();
        push_frame(7'h24, 7'h24, 7'h24, 7'h24, 4'hF);
        ack_exp.push_back(1'b1);
        do_load(16'h8888, 4'hF, 4'b0011);

        wait_fd();
        push_frame(7'h00, 7'h00, 7'h7F, 7'h7F, 4'b1100);
        ack_exp.push_back(1'b0);

        wait_fd();
        push_frame(7'h00, 7'h00, 7'h7F, 7'h7F, 4'b1100);
        ack_exp.push_back(1'b1);
        ack_exp.push_back(1'b1);
        repeat (2) @(negedge clk);
        do_load(16'h3C5E, 4'h0, 4'hF);
        repeat (12) @(negedge clk);
        value    = 16'h9704;
        dp_in    = 4'b1001;
        digit_en = 4'hF;
        load     = 1'b1;
        wait_fd();
        load     = 1'b0;
        push_frame(7'h06, 7'h12, 7'h46, 7'h30, 4'hF);
        ack_exp.push_back(1'b0);

        wait_fd();
        push_frame(7'h19, 7'h40, 7'h78, 7'h10, 4'b0110);

        wait_fd();
        push_frame(7'h19, 7'h40, 7'h78, 7'h10, 4'b0110);
        repeat (2) @(negedge clk);
        do_load(16'h5555, 4'hF, 4'hF);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk_reset_state();
        sb.delete();
        ack_exp.delete();
        repeat (2) @(negedge clk);
        push_blank();
        ack_exp.push_back(1'b0);
        reset_n = 1'b1;

        wait_fd();
        push_blank();
        ack_exp.push_back(1'b0);
        wait_fd();
        repeat (2) @(negedge clk);
        chk("sb_drained", 16'(sb.size()), 16'd0);
        chk("ack_drained", 16'(ack_exp.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
